// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared ISA opcodes, hazard-word bit map and bubble constant
//               for the 5-stage core pipeline latches.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_LINK   = 5'd31;

    localparam int RA_LSB  = 0;
    localparam int RB_LSB  = 5;
    localparam int WR_LSB  = 10;
    localparam int RWE_BIT = 18;
    localparam int LW_BIT  = 29;
    localparam int SW_BIT  = 30;
    localparam int W30_BIT = 31;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [4:0] insn_opcode(input logic [31:0] insn);
        return insn[31:27];
    endfunction

    function automatic logic [4:0] insn_rd(input logic [31:0] insn);
        return insn[26:22];
    endfunction

    function automatic logic [4:0] insn_rs(input logic [31:0] insn);
        return insn[21:17];
    endfunction

    function automatic logic [4:0] insn_rt(input logic [31:0] insn);
        return insn[16:12];
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/hazard_word_enc.sv
`default_nettype none
// ============================================================================
// Module      : hazard_word_enc
// Description : Combinational instruction -> 32-bit hazard word encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_word_enc
    import cpu_pkg::*;
(
    input  logic [31:0] i_insn,
    output logic [31:0] o_word
);

    logic [4:0] w_op;
    logic [4:0] w_rd;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_ra;
    logic [4:0] w_rb;
    logic [4:0] w_wr;
    logic       w_rwe;
    logic       w_lw;
    logic       w_sw;
    logic       w_w30;
    logic       w_unused_bits;

    assign w_op = insn_opcode(i_insn);
    assign w_rd = insn_rd(i_insn);
    assign w_rs = insn_rs(i_insn);
    assign w_rt = insn_rt(i_insn);

    // Immediate / aluop / shamt bits never affect register hazards.
    assign w_unused_bits = ^i_insn[11:0];

    always_comb begin
        w_ra  = 5'd0;
        w_rb  = 5'd0;
        w_wr  = 5'd0;
        w_rwe = 1'b0;
        w_lw  = 1'b0;
        w_sw  = 1'b0;
        w_w30 = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_ra  = w_rs;
                w_rb  = w_rt;
                w_wr  = w_rd;
                w_rwe = 1'b1;
            end
            OP_ADDI: begin
                w_ra  = w_rs;
                w_wr  = w_rd;
                w_rwe = 1'b1;
            end
            OP_LW: begin
                w_ra  = w_rs;
                w_wr  = w_rd;
                w_rwe = 1'b1;
                w_lw  = 1'b1;
            end
            OP_SW: begin
                w_ra = w_rs;
                w_rb = w_rd;
                w_sw = 1'b1;
            end
            OP_BNE, OP_BLT: begin
                w_ra = w_rd;
                w_rb = w_rs;
            end
            OP_JR: begin
                w_ra = w_rd;
            end
            OP_JAL: begin
                w_wr  = REG_LINK;
                w_rwe = 1'b1;
            end
            OP_BEX: begin
                w_ra = REG_STATUS;
            end
            OP_SETX: begin
                w_wr  = REG_STATUS;
                w_rwe = 1'b1;
                w_w30 = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_word                 = 32'h0000_0000;
        o_word[RA_LSB +: 5]    = w_ra;
        o_word[RB_LSB +: 5]    = w_rb;
        o_word[WR_LSB +: 5]    = w_wr;
        o_word[RWE_BIT]        = w_rwe;
        o_word[LW_BIT]         = w_lw;
        o_word[SW_BIT]         = w_sw;
        o_word[W30_BIT]        = w_w30;
    end

endmodule : hazard_word_enc
`default_nettype wire

// File: rtl/dx_pipe_latch.sv
`default_nettype none
// ============================================================================
// Module      : dx_pipe_latch
// Description : Decode/execute pipeline register with hazard word, stall /
//               multdiv hold, flush bubble and saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dx_pipe_latch
    import cpu_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_INSN = NOP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      fd_insn,
    input  logic [31:0]      fd_pc,
    input  logic             fd_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             md_busy,
    output logic [31:0]      dx_insn,
    output logic [31:0]      dx_pc,
    output logic [31:0]      dx_byp,
    output logic             dx_valid,
    output logic             pc_en,
    output logic             fd_en,
    output logic             xm_bubble,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_insn;
    logic [31:0]      r_pc;
    logic [31:0]      r_byp;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_word;
    logic             w_busy_e;
    logic             w_stall_e;
    logic             w_hold;

    hazard_word_enc u_enc (
        .i_insn (fd_insn),
        .o_word (w_word)
    );

    // A hold is only meaningful while DX carries a real instruction.
    assign w_busy_e  = md_busy & r_valid;
    assign w_stall_e = stall & r_valid;
    assign w_hold    = w_busy_e | w_stall_e;

    assign pc_en     = reset | ~w_hold;
    assign fd_en     = reset | ~w_hold;
    assign xm_bubble = reset | w_hold;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_insn  <= NOP_INSN;
            r_pc    <= 32'h0000_0000;
            r_byp   <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (w_busy_e) begin
            r_insn  <= r_insn;
        end else if (w_stall_e) begin
            if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end else if (flush) begin
            r_insn  <= NOP_INSN;
            r_pc    <= fd_pc;
            r_byp   <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else begin
            r_insn  <= fd_insn;
            r_pc    <= fd_pc;
            r_byp   <= fd_valid ? w_word : 32'h0000_0000;
            r_valid <= fd_valid;
        end
    end

    assign dx_insn    = r_insn;
    assign dx_pc      = r_pc;
    assign dx_byp     = r_byp;
    assign dx_valid   = r_valid;
    assign bubble_cnt = r_cnt;

endmodule : dx_pipe_latch
`default_nettype wire
